// File: rtl/mvb_discard_stats_pkg.sv
// Shared types and helpers for the MVB discard statistics block.
package mvb_discard_stats_pkg;

    // State encodings kept as plain constants so older code can compare against them
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DRAIN   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        DRAIN   = ST_DRAIN,
        CAPTURE = ST_CAPTURE
    } snap_state_t;

    // Widest accumulator the helper supports; narrower counters are zero-extended
    localparam int MAX_CNT_W = 64;
    typedef logic [MAX_CNT_W-1:0] cnt_t;

    // Saturating add: returns {saturated, result}. cnt is assumed <= max_val.
    function automatic logic [MAX_CNT_W:0] sat_add(input cnt_t cnt, input cnt_t inc,
                                                   input cnt_t max_val);
        if (inc > (max_val - cnt))
            sat_add = {1'b1, max_val};
        else
            sat_add = {1'b0, cnt + inc};
    endfunction

endpackage

// File: rtl/mvb_discard_popcnt.sv
// Combinational population count over one MVB word's worth of flags.
module mvb_discard_popcnt #(
    parameter int REGIONS = 4,
    parameter int CW      = $clog2(REGIONS + 1)
) (
    input  logic [REGIONS-1:0] bits,
    output logic [CW-1:0]      cnt
);

    // Sum of set bits
    always_comb begin
        cnt = '0;
        for (int i = 0; i < REGIONS; i++)
            cnt = cnt + CW'(bits[i]);
    end

endmodule

// File: rtl/mvb_discard_stats.sv
// Per-channel RX discard statistics: counts frames seen / discarded from the
// MVB discard stream and offers a drained snapshot (optionally clearing).
// CNT_WIDTH must be at least clog2(REGIONS+1) and at most 64.
module mvb_discard_stats
    import mvb_discard_stats_pkg::*;
#(
    parameter int REGIONS   = 4,
    parameter int CNT_WIDTH = 48
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [REGIONS-1:0]   RX_MVB_DATA,
    input  logic [REGIONS-1:0]   RX_MVB_VLD,
    input  logic                 RX_MVB_SRC_RDY,
    output logic                 RX_MVB_DST_RDY,
    input  logic                 SNAP_REQ,
    input  logic                 SNAP_CLR,
    output logic                 SNAP_ACK,
    output logic [CNT_WIDTH-1:0] SNAP_TOTAL,
    output logic [CNT_WIDTH-1:0] SNAP_DISC,
    output logic                 SNAP_OVF
);

    localparam int                   INC_W   = $clog2(REGIONS + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                 dst_rdy;
    logic                 beat;
    logic [REGIONS-1:0]   vld_m, dis_m;
    logic [INC_W-1:0]     pc_tot, pc_dis;
    logic [INC_W-1:0]     inc_tot, inc_dis;
    logic [CNT_WIDTH-1:0] live_tot, live_dis;
    logic                 live_ovf;
    logic [MAX_CNT_W:0]   sat_tot, sat_dis;
    snap_state_t          state;
    logic                 clr_q;
    logic                 unused_sat;

    assign beat           = RX_MVB_SRC_RDY & dst_rdy;
    assign vld_m          = beat ? RX_MVB_VLD : '0;
    assign dis_m          = vld_m & RX_MVB_DATA;
    assign RX_MVB_DST_RDY = dst_rdy;

    mvb_discard_popcnt #(.REGIONS(REGIONS), .CW(INC_W)) u_pc_tot (.bits(vld_m), .cnt(pc_tot));
    mvb_discard_popcnt #(.REGIONS(REGIONS), .CW(INC_W)) u_pc_dis (.bits(dis_m), .cnt(pc_dis));

    assign sat_tot    = sat_add(cnt_t'(live_tot), cnt_t'(inc_tot), cnt_t'(CNT_MAX));
    assign sat_dis    = sat_add(cnt_t'(live_dis), cnt_t'(inc_dis), cnt_t'(CNT_MAX));
    // Upper bits beyond CNT_WIDTH are always zero
    assign unused_sat = ^{sat_tot, sat_dis};

    // Sink is always ready once out of reset
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) dst_rdy <= 1'b0;
        else       dst_rdy <= 1'b1;
    end

    // Stage 1: register per-beat increments
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            inc_tot <= '0;
            inc_dis <= '0;
        end else begin
            inc_tot <= pc_tot;
            inc_dis <= pc_dis;
        end
    end

    // Stage 2: saturating live accumulators; a clearing capture restarts them from the in-flight beat
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            live_tot <= '0;
            live_dis <= '0;
            live_ovf <= 1'b0;
        end else if (state == CAPTURE && clr_q) begin
            live_tot <= CNT_WIDTH'(inc_tot);
            live_dis <= CNT_WIDTH'(inc_dis);
            live_ovf <= 1'b0;
        end else begin
            live_tot <= sat_tot[CNT_WIDTH-1:0];
            live_dis <= sat_dis[CNT_WIDTH-1:0];
            live_ovf <= live_ovf | sat_tot[MAX_CNT_W] | sat_dis[MAX_CNT_W];
        end
    end

    // Snapshot FSM: one drain cycle lets the last accepted beat reach the accumulators
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            clr_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (SNAP_REQ) begin
                    state <= DRAIN;
                    clr_q <= SNAP_CLR;
                end
                DRAIN:   state <= CAPTURE;
                CAPTURE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Snapshot registers and acknowledge pulse
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            SNAP_TOTAL <= '0;
            SNAP_DISC  <= '0;
            SNAP_OVF   <= 1'b0;
            SNAP_ACK   <= 1'b0;
        end else begin
            SNAP_ACK <= (state == CAPTURE);
            if (state == CAPTURE) begin
                SNAP_TOTAL <= live_tot;
                SNAP_DISC  <= live_dis;
                SNAP_OVF   <= live_ovf;
            end
        end
    end

endmodule

// File: tb/tb_mvb_discard_stats.sv
// Scoreboard bench: stimulus pushes expected snapshots (values and ACK cycle),
// per-DUT monitors pop and compare on every SNAP_ACK.
module tb_mvb_discard_stats;

    logic       CLK = 1'b0;
    logic       rst;
    logic [3:0] data, vld;
    logic       src;
    logic       req_b, clr_b, req_s, clr_s;

    logic        dst_b, ack_b, ovf_b;
    logic [47:0] tot_b, dis_b;
    logic        dst_s, ack_s, ovf_s;
    logic [3:0]  tot_s, dis_s;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [47:0] tot;
        logic [47:0] dis;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t q_b[$];
    exp_t q_s[$];

    mvb_discard_stats #(.REGIONS(4), .CNT_WIDTH(48)) dut_b (
        .CLK(CLK), .RESET(rst),
        .RX_MVB_DATA(data), .RX_MVB_VLD(vld), .RX_MVB_SRC_RDY(src), .RX_MVB_DST_RDY(dst_b),
        .SNAP_REQ(req_b), .SNAP_CLR(clr_b), .SNAP_ACK(ack_b),
        .SNAP_TOTAL(tot_b), .SNAP_DISC(dis_b), .SNAP_OVF(ovf_b)
    );

    mvb_discard_stats #(.REGIONS(4), .CNT_WIDTH(4)) dut_s (
        .CLK(CLK), .RESET(rst),
        .RX_MVB_DATA(data), .RX_MVB_VLD(vld), .RX_MVB_SRC_RDY(src), .RX_MVB_DST_RDY(dst_s),
        .SNAP_REQ(req_s), .SNAP_CLR(clr_s), .SNAP_ACK(ack_s),
        .SNAP_TOTAL(tot_s), .SNAP_DISC(dis_s), .SNAP_OVF(ovf_s)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_b(input logic [47:0] t, input logic [47:0] d, input logic o, input int c);
        q_b.push_back('{t, d, o, c});
    endtask

    task automatic push_s(input logic [47:0] t, input logic [47:0] d, input logic o, input int c);
        q_s.push_back('{t, d, o, c});
    endtask

    // Monitor for the 48-bit instance
    always @(negedge CLK) begin
        if (ack_b) begin
            if (q_b.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_unexpected_ack: got ack expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                chk("b_ack_cycle", 64'(cyc), 64'(e.cyc));
                chk("b_total", 64'(tot_b), 64'(e.tot));
                chk("b_disc", 64'(dis_b), 64'(e.dis));
                chk("b_ovf", 64'(ovf_b), 64'(e.ovf));
            end
        end
    end

    // Monitor for the 4-bit (saturation) instance
    always @(negedge CLK) begin
        if (ack_s) begin
            if (q_s.size() == 0) begin
                total++;
                bad++;
                $display("FAIL s_unexpected_ack: got ack expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q_s.pop_front();
                chk("s_ack_cycle", 64'(cyc), 64'(e.cyc));
                chk("s_total", 64'(tot_s), 64'(e.tot));
                chk("s_disc", 64'(dis_s), 64'(e.dis));
                chk("s_ovf", 64'(ovf_s), 64'(e.ovf));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_in();
        src  = 1'b0;
        vld  = 4'b0000;
        data = 4'b0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            if (q_b.size() == 0 && q_s.size() == 0) break;
            tick();
        end
        total++;
        if (q_b.size() != 0 || q_s.size() != 0) begin
            bad++;
            $display("FAIL ack_timeout: got %0d/%0d pending expected 0", q_b.size(), q_s.size());
            q_b.delete();
            q_s.delete();
        end
    endtask

    initial begin
        rst   = 1'b1;
        req_b = 1'b0; clr_b = 1'b0;
        req_s = 1'b0; clr_s = 1'b0;
        idle_in();
        tick();
        tick();
        // Reset state
        chk("rst_dst_rdy_b", 64'(dst_b), 64'd0);
        chk("rst_dst_rdy_s", 64'(dst_s), 64'd0);
        chk("rst_ack", 64'(ack_b), 64'd0);
        chk("rst_total", 64'(tot_b), 64'd0);
        chk("rst_disc", 64'(dis_b), 64'd0);
        chk("rst_ovf", 64'(ovf_b), 64'd0);
        rst = 1'b0;
        tick();
        chk("dst_rdy_after_rst", 64'(dst_b), 64'd1);

        // 1: single beat, snapshot next cycle
        src = 1'b1; vld = 4'b1111; data = 4'b0101;
        tick();
        idle_in();
        req_b = 1'b1;
        push_b(48'd4, 48'd2, 1'b0, cyc + 3);
        tick();
        req_b = 1'b0;
        wait_done();

        // 2: toggling SRC_RDY, request during the 5th beat
        do_reset();
        for (int i = 0; i < 10; i++) begin
            src = (i % 2 == 0); vld = 4'b1111; data = 4'b0000;
            req_b = (i == 8);
            if (i == 8) push_b(48'd20, 48'd0, 1'b0, cyc + 3);
            tick();
        end
        idle_in();
        req_b = 1'b0;
        wait_done();

        // 3: clearing snapshot under full-rate traffic
        do_reset();
        for (int i = 0; i < 10; i++) begin
            src = 1'b1; vld = 4'b0011; data = 4'b0001;
            req_b = (i == 3 || i == 9);
            clr_b = (i == 3);
            if (i == 3) push_b(48'd8, 48'd4, 1'b0, cyc + 3);
            if (i == 9) push_b(48'd12, 48'd6, 1'b0, cyc + 3);
            tick();
        end
        idle_in();
        req_b = 1'b0; clr_b = 1'b0;
        wait_done();
        req_b = 1'b1;
        push_b(48'd12, 48'd6, 1'b0, cyc + 3);
        tick();
        req_b = 1'b0;
        wait_done();

        // 4: 4-bit counters saturate, clear restarts from the in-flight beat
        do_reset();
        for (int i = 0; i < 10; i++) begin
            src = (i <= 4 || i == 6); vld = 4'b1111; data = 4'b0011;
            req_s = (i == 5 || i == 9);
            clr_s = (i == 5);
            if (i == 5) push_s(48'd15, 48'd10, 1'b1, cyc + 3);
            if (i == 9) push_s(48'd4, 48'd2, 1'b0, cyc + 3);
            tick();
        end
        idle_in();
        req_s = 1'b0; clr_s = 1'b0;
        wait_done();

        // 5: held request gives two ACKs; empty-VLD beats count nothing
        do_reset();
        src = 1'b1; vld = 4'b1001; data = 4'b1000;
        tick();
        for (int i = 0; i < 6; i++) begin
            src = 1'b1; vld = 4'b0000; data = 4'b1111;
            req_b = 1'b1;
            if (i == 0) begin
                push_b(48'd2, 48'd1, 1'b0, cyc + 3);
                push_b(48'd2, 48'd1, 1'b0, cyc + 6);
            end
            tick();
        end
        idle_in();
        req_b = 1'b0;
        wait_done();

        // 6: reset while draining drops the snapshot
        src = 1'b1; vld = 4'b1111; data = 4'b0000;
        tick();
        idle_in();
        req_b = 1'b1;
        tick();
        req_b = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_dst_rdy", 64'(dst_b), 64'd0);
        chk("mid_rst_ack", 64'(ack_b), 64'd0);
        chk("mid_rst_total", 64'(tot_b), 64'd0);
        chk("mid_rst_disc", 64'(dis_b), 64'd0);
        chk("mid_rst_ovf", 64'(ovf_b), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_dst_rdy", 64'(dst_b), 64'd1);
        src = 1'b1; vld = 4'b0001; data = 4'b0000;
        tick();
        idle_in();
        req_b = 1'b1;
        push_b(48'd1, 48'd0, 1'b0, cyc + 3);
        tick();
        req_b = 1'b0;
        wait_done();
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
